// File: rtl/obi_wb_bridge.sv
// obi_wb_bridge
//   Converts a core-side OBI request/grant/rvalid port into a Wishbone
//   classic master. At most one transaction is outstanding. Every grant
//   produces exactly one response: writes included, and bus errors or a
//   watchdog timeout are reported through err_o.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_i / gnt_o              OBI request / grant (grant only while idle)
//   addr_i, we_i, be_i,        OBI request attributes, sampled in the
//   wdata_i                      grant cycle only
//   rvalid_o, rdata_o, err_o   OBI response (rdata_o is 0 for writes,
//                                errors and whenever rvalid_o is low)
//   wb_cyc_o, wb_stb_o         Wishbone cycle/strobe (always equal)
//   wb_we_o, wb_sel_o,         Wishbone request attributes, held stable
//   wb_adr_o, wb_dat_o           for the whole bus cycle
//   wb_dat_i, wb_ack_i,        Wishbone response (ignored outside a cycle)
//   wb_err_i
//   busy_o                     high whenever a transaction is in flight
module obi_wb_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned REG_RESP       = 1,
  localparam int unsigned SEL_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [SEL_WIDTH-1:0]  be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [SEL_WIDTH-1:0]  wb_sel_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  output logic                  busy_o
);

  // A disabled watchdog still gets a 1-bit counter so the vector stays legal.
  localparam int unsigned CNT_W     = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] adr_q,   adr_d;
  logic                  we_q,    we_d;
  logic [SEL_WIDTH-1:0]  sel_q,   sel_d;
  logic [DATA_WIDTH-1:0] dat_q,   dat_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q,   err_d;

  logic                  timeout_hit;
  logic                  bus_err;
  logic                  term;
  logic [DATA_WIDTH-1:0] rd_val;

  // Counter equals the number of BUS cycles already completed, so matching
  // TIMEOUT_CYCLES-1 ends the cycle in its TIMEOUT_CYCLES-th clock.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
  // A timeout is reported exactly like a slave error, and errors beat acks.
  assign bus_err     = wb_err_i | timeout_hit;
  assign term        = wb_ack_i | bus_err;
  assign rd_val      = (!we_q && !bus_err) ? wb_dat_i : '0;

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    we_d     = we_q;
    sel_d    = sel_q;
    dat_d    = dat_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    gnt_o    = 1'b0;
    rvalid_o = 1'b0;
    rdata_o  = '0;
    err_o    = 1'b0;
    wb_cyc_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_sel_o = '0;
    wb_adr_o = '0;
    wb_dat_o = '0;

    unique case (state_q)
      S_IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          adr_d   = addr_i;
          we_d    = we_i;
          sel_d   = be_i;
          dat_d   = wdata_i;
          cnt_d   = '0;
          state_d = S_BUS;
        end
      end

      S_BUS: begin
        wb_cyc_o = 1'b1;
        wb_we_o  = we_q;
        wb_sel_o = sel_q;
        wb_adr_o = adr_q;
        wb_dat_o = dat_q;
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (term) begin
          if (REG_RESP != 0) begin
            rdata_d = rd_val;
            err_d   = bus_err;
            state_d = S_RESP;
          end else begin
            rvalid_o = 1'b1;
            rdata_o  = rd_val;
            err_o    = bus_err;
            state_d  = S_IDLE;
          end
        end
      end

      S_RESP: begin
        rvalid_o = 1'b1;
        rdata_o  = rdata_q;
        err_o    = err_q;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Asynchronous reset drops wb_cyc_o immediately and discards any response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign wb_stb_o = wb_cyc_o;
  assign busy_o   = (state_q != S_IDLE);

endmodule

// File: tb/tb_obi_wb_bridge.sv
`timescale 1ns/1ps
// Bench for obi_wb_bridge: instance 0 has a registered response, instance 1
// a combinational one; both use an 8-cycle watchdog.
module tb_obi_wb_bridge;

  localparam int TO = 8;

  logic        clk;
  logic        rst_n;
  logic        req    [2];
  logic        gnt    [2];
  logic [31:0] addr   [2];
  logic        we     [2];
  logic [3:0]  be     [2];
  logic [31:0] wdata  [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        erro   [2];
  logic        cyc    [2];
  logic        stb    [2];
  logic        wwe    [2];
  logic [3:0]  wsel   [2];
  logic [31:0] wadr   [2];
  logic [31:0] wdo    [2];
  logic [31:0] wdi    [2];
  logic        ack    [2];
  logic        werr   [2];
  logic        busy   [2];

  int  n_chk  = 0;
  int  n_pass = 0;
  time last_rv_t;

  obi_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO), .REG_RESP(1)) u_reg (
    .clk(clk), .rst_n(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
    .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .err_o(erro[0]), .wb_cyc_o(cyc[0]), .wb_stb_o(stb[0]),
    .wb_we_o(wwe[0]), .wb_sel_o(wsel[0]), .wb_adr_o(wadr[0]), .wb_dat_o(wdo[0]),
    .wb_dat_i(wdi[0]), .wb_ack_i(ack[0]), .wb_err_i(werr[0]), .busy_o(busy[0]));

  obi_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO), .REG_RESP(0)) u_comb (
    .clk(clk), .rst_n(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
    .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .err_o(erro[1]), .wb_cyc_o(cyc[1]), .wb_stb_o(stb[1]),
    .wb_we_o(wwe[1]), .wb_sel_o(wsel[1]), .wb_adr_o(wadr[1]), .wb_dat_o(wdo[1]),
    .wb_dat_i(wdi[1]), .wb_ack_i(ack[1]), .wb_err_i(werr[1]), .busy_o(busy[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One OBI transaction on instance d. kind: 0 ack, 1 err, 2 ack+err,
  // 3 silent slave. The slave responds 'waits' cycles after cyc rises.
  // Expected behaviour is derived from the bridge rules: the bus cycle lasts
  // waits+1 clocks or the watchdog length, the response follows one clock
  // later when registered, and data is returned only for clean reads.
  task automatic run_txn(input int d, input logic [31:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] wd, input int waits,
                         input int kind, input logic [31:0] rd, input string nm);
    int          n_bus, exp_rv, cyc_seen, first_cyc, rv_seen, rv_at;
    logic        timed, exp_err, got_err, bad_hold, bad_gnt, bad_zero;
    logic [31:0] exp_rd, got_rd;
    timed   = (kind == 3) || (waits + 1 > TO);
    n_bus   = timed ? TO : waits + 1;
    exp_err = (kind != 0) || timed;
    exp_rd  = (w || exp_err) ? 32'h0 : rd;
    exp_rv  = n_bus + ((d == 0) ? 1 : 0);
    cyc_seen = 0; first_cyc = -1; rv_seen = 0; rv_at = -1;
    bad_hold = 0; bad_gnt = 0; bad_zero = 0; got_err = 0; got_rd = 0;

    @(negedge clk);
    req[d] = 1'b1; addr[d] = a; we[d] = w; be[d] = b; wdata[d] = wd;
    ack[d] = 1'b0; werr[d] = 1'b0; wdi[d] = $urandom;
    #1;
    n_chk++;
    if (gnt[d] !== 1'b1 || cyc[d] !== 1'b0 || rvalid[d] !== 1'b0)
      $display("FAIL %s grant: gnt=%b cyc=%b rvalid=%b, want 1 0 0", nm, gnt[d], cyc[d], rvalid[d]);
    else n_pass++;

    for (int k = 1; k <= exp_rv; k++) begin
      @(negedge clk);
      // Request-side inputs are scrambled: the bridge must ignore them now.
      req[d]   = (k < exp_rv) ? 1'($urandom_range(0, 1)) : 1'b0;
      addr[d]  = $urandom; we[d] = ~w; be[d] = ~b; wdata[d] = $urandom;
      ack[d]   = 1'b0; werr[d] = 1'b0; wdi[d] = $urandom;
      if (kind != 3 && k == waits + 1) begin
        wdi[d]  = rd;
        ack[d]  = (kind != 1);
        werr[d] = (kind != 0);
      end
      #1;
      if (gnt[d] !== 1'b0) bad_gnt = 1;
      if (cyc[d] !== stb[d]) bad_hold = 1;
      if (cyc[d] === 1'b1) begin
        cyc_seen++;
        if (first_cyc < 0) first_cyc = k;
        if (wadr[d] !== a || wwe[d] !== w || wsel[d] !== b || wdo[d] !== wd) bad_hold = 1;
      end
      if (rvalid[d] === 1'b1) begin
        rv_seen++; rv_at = k; got_rd = rdata[d]; got_err = erro[d]; last_rv_t = $time;
      end else if (rdata[d] !== 32'h0) bad_zero = 1;
    end

    n_chk++;
    if (first_cyc != 1 || cyc_seen != n_bus)
      $display("FAIL %s cyc_span: start=%0d cycles=%0d, want start=1 cycles=%0d", nm, first_cyc, cyc_seen, n_bus);
    else n_pass++;
    n_chk++;
    if (bad_hold) $display("FAIL %s wb_hold: bus fields got=%b want=0 changes", nm, bad_hold);
    else n_pass++;
    n_chk++;
    if (bad_gnt) $display("FAIL %s gnt_busy: gnt while busy got=%b want=0", nm, bad_gnt);
    else n_pass++;
    n_chk++;
    if (rv_seen != 1 || rv_at != exp_rv)
      $display("FAIL %s rvalid: count=%0d at=%0d, want count=1 at=%0d", nm, rv_seen, rv_at, exp_rv);
    else n_pass++;
    n_chk++;
    if (got_rd !== exp_rd || got_err !== exp_err)
      $display("FAIL %s resp: rdata=%h err=%b, want rdata=%h err=%b", nm, got_rd, got_err, exp_rd, exp_err);
    else n_pass++;
    n_chk++;
    if (bad_zero) $display("FAIL %s rdata_idle: nonzero rdata without rvalid got=%b want=0", nm, bad_zero);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 0; addr[d] = 0; we[d] = 0; be[d] = 0; wdata[d] = 0;
      wdi[d] = 0; ack[d] = 0; werr[d] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (cyc[d] !== 0 || stb[d] !== 0 || rvalid[d] !== 0 || rdata[d] !== 0 || erro[d] !== 0 ||
          busy[d] !== 0 || gnt[d] !== 0 || wadr[d] !== 0 || wdo[d] !== 0 || wsel[d] !== 0 || wwe[d] !== 0)
        $display("FAIL reset_outputs[%0d]: cyc=%b rv=%b rdata=%h busy=%b gnt=%b adr=%h, want all 0",
                 d, cyc[d], rvalid[d], rdata[d], busy[d], gnt[d], wadr[d]);
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Pulse req inside one clock phase: gnt must follow it combinationally.
    req[0] = 1'b1; #1;
    n_chk++;
    if (gnt[0] !== 1'b1) $display("FAIL gnt_follow_hi: got=%b want=1", gnt[0]); else n_pass++;
    req[0] = 1'b0; #1;
    n_chk++;
    if (gnt[0] !== 1'b0) $display("FAIL gnt_follow_lo: got=%b want=0", gnt[0]); else n_pass++;
  endtask

  task automatic test_read_zero_wait();
    run_txn(0, 32'h100, 1'b0, 4'hF, 32'h0, 0, 0, 32'hDEADBEEF, "read_zw_reg");
    run_txn(1, 32'h104, 1'b0, 4'hF, 32'h0, 0, 0, 32'hCAFEF00D, "read_zw_comb");
  endtask

  task automatic test_write_wait();
    run_txn(0, 32'h200, 1'b1, 4'b0011, 32'h12345678, 3, 0, 32'hFFFFFFFF, "write_wait_reg");
    run_txn(1, 32'h204, 1'b1, 4'b0011, 32'h12345678, 3, 0, 32'hFFFFFFFF, "write_wait_comb");
  endtask

  task automatic test_bus_error();
    run_txn(0, 32'h300, 1'b0, 4'hF, 32'h0, 1, 2, 32'hA5A5A5A5, "ack_err_reg");
    run_txn(1, 32'h304, 1'b0, 4'hF, 32'h0, 2, 2, 32'hA5A5A5A5, "ack_err_comb");
    run_txn(0, 32'h308, 1'b1, 4'hC, 32'h55AA55AA, 0, 1, 32'h1, "err_write_reg");
  endtask

  task automatic test_timeout();
    run_txn(0, 32'h400, 1'b0, 4'hF, 32'h0, 0, 3, 32'h0, "timeout_reg");
    run_txn(0, 32'h404, 1'b0, 4'hF, 32'h0, 0, 0, 32'h0BADF00D, "after_timeout_reg");
    run_txn(1, 32'h408, 1'b1, 4'hF, 32'h77777777, 0, 3, 32'h0, "timeout_comb");
    run_txn(1, 32'h40C, 1'b0, 4'hF, 32'h0, 1, 0, 32'h13579BDF, "after_timeout_comb");
  endtask

  task automatic test_back_to_back();
    time prev_t;
    for (int i = 0; i < 4; i++) begin
      run_txn(1, 32'h500 + 32'(4 * i), 1'b0, 4'hF, 32'h0, 0, 0, 32'h1000 + 32'(i), "b2b_comb");
      if (i > 0) begin
        n_chk++;
        if (last_rv_t - prev_t != 20)
          $display("FAIL b2b_spacing: got=%0t want=20", last_rv_t - prev_t);
        else n_pass++;
      end
      prev_t = last_rv_t;
    end
  endtask

  task automatic test_stray_ack();
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      req[d] = 1'b0; ack[d] = 1'b1; werr[d] = 1'($urandom_range(0, 1)); wdi[d] = $urandom;
      #1;
      n_chk++;
      if (rvalid[d] !== 0 || cyc[d] !== 0 || rdata[d] !== 0)
        $display("FAIL stray_ack[%0d]: rvalid=%b cyc=%b rdata=%h, want 0", d, rvalid[d], cyc[d], rdata[d]);
      else n_pass++;
      @(negedge clk);
      ack[d] = 1'b0; werr[d] = 1'b0;
      #1;
      n_chk++;
      if (rvalid[d] !== 0 || busy[d] !== 0)
        $display("FAIL stray_after[%0d]: rvalid=%b busy=%b, want 0 0", d, rvalid[d], busy[d]);
      else n_pass++;
    end
    run_txn(1, 32'h600, 1'b0, 4'hF, 32'h0, 0, 0, 32'h600DDA7A, "post_stray_comb");
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd;
    logic        w;
    logic [3:0]  b;
    int          r, kind, waits;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; wd = $urandom; rd = $urandom; w = 1'($urandom_range(0, 1));
      b = 4'($urandom_range(1, 15)); waits = $urandom_range(0, 5);
      r = $urandom_range(0, 9);
      kind = (r < 6) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : 3;
      run_txn(i % 2, a, w, b, wd, waits, kind, rd, "random");
    end
  endtask

  task automatic test_reset_mid();
    logic bad_rv;
    bad_rv = 0;
    @(negedge clk);
    req[0] = 1'b1; addr[0] = 32'h700; we[0] = 1'b0; be[0] = 4'hF;
    @(negedge clk);
    req[0] = 1'b0;
    #1;
    n_chk++;
    if (cyc[0] !== 1'b1) $display("FAIL mid_cyc_up: got=%b want=1", cyc[0]); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (cyc[0] !== 1'b0 || stb[0] !== 1'b0 || busy[0] !== 1'b0)
      $display("FAIL mid_async_drop: cyc=%b stb=%b busy=%b, want 0 0 0", cyc[0], stb[0], busy[0]);
    else n_pass++;
    @(negedge clk);
    ack[0] = 1'b1; wdi[0] = 32'hBAD0BAD0;
    @(negedge clk);
    ack[0] = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      if (rvalid[0] !== 1'b0 || cyc[0] !== 1'b0) bad_rv = 1;
    end
    n_chk++;
    if (bad_rv) $display("FAIL mid_no_resp: stray response got=%b want=0", bad_rv); else n_pass++;
    run_txn(0, 32'h704, 1'b0, 4'hF, 32'h0, 1, 0, 32'h5EED1234, "post_reset_reg");
  endtask

  initial begin
    last_rv_t = 0;
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_bus_error();
    test_timeout();
    test_back_to_back();
    test_stray_ack();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/obi_wb_bridge.md
# obi_wb_bridge

Parametrised bridge converting a core-side OBI request/grant/rvalid port into a Wishbone classic master with byte selects, bus-error propagation and a watchdog timeout. Sits between a processor core's instruction or data port and the Controller's Wishbone memory bus, one instance per port. It replaces ad-hoc ack-to-grant glue with a proper FSM:

- a response is returned for writes as well as reads;
- a hung slave cannot stall the core.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width on both sides.
- DATA_WIDTH, 32, data width; must be a multiple of 8; SEL_WIDTH = DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, max cycles in BUS before forced error; 0 disables timeout.
- REG_RESP, 1, 1 = response registered (+1 cycle); 0 = response combinational from ack/err.

Ports:
- clk  in  1  clock; only clock in the block.
- rst_n  in  1  asynchronous, active-low reset.
- req_i  in  1  OBI request.
- gnt_o  out  1  OBI grant.
- addr_i  in  ADDR_WIDTH  request address.
- we_i  in  1  1 = write.
- be_i  in  SEL_WIDTH  byte enables.
- wdata_i  in  DATA_WIDTH  write data.
- rvalid_o  out  1  response valid, one pulse per granted request.
- rdata_o  out  DATA_WIDTH  read data; 0 for writes and errors.
- err_o  out  1  response error, qualified by rvalid_o.
- wb_cyc_o, wb_stb_o  out  1 each  Wishbone cycle/strobe; always equal.
- wb_we_o  out  1  Wishbone write enable.
- wb_sel_o  out  SEL_WIDTH  byte selects.
- wb_adr_o  out  ADDR_WIDTH  Wishbone address.
- wb_dat_o  out  DATA_WIDTH  Wishbone write data.
- wb_dat_i  in  DATA_WIDTH  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_err_i  in  1  Wishbone error.
- busy_o  out  1  high whenever state is not IDLE.

## Operation
FSM states:
- **IDLE**
  - gnt_o = req_i (combinational); all other outputs low or 0.
  - On req_i & gnt_o: latch addr, we, be, wdata into holding registers; clear timeout counter; go to BUS.
- **BUS**
  - wb_cyc_o = wb_stb_o = 1; wb_adr_o/wb_we_o/wb_sel_o/wb_dat_o driven from holding registers, stable for the whole cycle; gnt_o = 0.
  - Termination is the first of: wb_err_i, wb_ack_i, or timeout counter == TIMEOUT_CYCLES-1 (when TIMEOUT_CYCLES != 0).
  - err wins over ack when both are high in the same cycle.
  - Timeout is treated as an error.
  - Termination outcome:
    - REG_RESP=1: capture rdata (wb_dat_i if read and no error, else 0) and err; go to RESP.
    - REG_RESP=0: rvalid_o/err_o/rdata_o driven combinationally in the terminating cycle; go to IDLE.
- **RESP** (REG_RESP=1 only)
  - rvalid_o = 1 for exactly one cycle with the registered rdata_o/err_o; gnt_o = 0; then go to IDLE.
- Response rules:
  - Exactly one rvalid_o per grant, in order.
  - Writes get rvalid_o with rdata_o = 0.
  - rdata_o = 0 whenever rvalid_o = 0.
- Timeout counter: width $clog2(TIMEOUT_CYCLES+1); increments each BUS cycle; saturates; cleared on entry to BUS.
- wb_ack_i/wb_err_i are ignored outside BUS (stray acks have no effect).
- At most one transaction is outstanding.

## Timing
- Reset (async, rst_n low): state IDLE; gnt_o follows req_i after reset deassertion; all other outputs 0. Holding registers, counter and response registers are cleared.
- Reset mid-transaction: wb_cyc_o drops immediately (asynchronously); the pending response is discarded.
- Grant at cycle C0 → wb_cyc_o high from C1.
- A zero-wait slave acks in C1:
  - REG_RESP=1: rvalid_o in C2, next gnt_o possible in C3; 3 cycles per access.
  - REG_RESP=0: rvalid_o in C1, next gnt_o possible in C2; 2 cycles per access.
- Ack at cycle Cn → wb_cyc_o low at Cn+1.
- Timeout: with no ack, cyc stays high for exactly TIMEOUT_CYCLES cycles; termination in the last of those cycles.
- Request inputs are sampled only in the grant cycle; changes afterward have no effect.

## Test plan
- **Zero-wait read, REG_RESP=1:** req at C0, addr 0x100, slave acks C1 with 0xDEADBEEF → wb_adr_o = 0x100 in C1; rvalid_o in C2 with rdata_o = 0xDEADBEEF, err_o = 0; gnt_o = 0 until C3.
- **Write with wait states:** we_i = 1, be_i = 4'b0011, wdata 0x12345678, ack after 3 wait cycles → wb_sel_o = 0011 and wb_dat_o = 0x12345678 held for all 4 cyc cycles; one rvalid_o with rdata_o = 0, err_o = 0.
- **Bus error:** wb_ack_i and wb_err_i both high in the same cycle on a read → rvalid_o with err_o = 1, rdata_o = 0.
- **Timeout:** TIMEOUT_CYCLES = 8, slave never acks → wb_cyc_o high exactly 8 cycles; rvalid_o with err_o = 1; next request is then granted normally.
- **REG_RESP=0 back-to-back:** 4 reads against a zero-wait slave → rvalid_o every 2 cycles, in order, with correct data; stray wb_ack_i in IDLE produces no rvalid_o.
- **Reset mid-BUS:** rst_n pulled low while wb_cyc_o = 1 → wb_cyc_o drops without waiting for clk; no rvalid_o after release; first post-reset request completes correctly.
